// File: rtl/spi_flash_share_arbiter.sv
// Two-master arbiter for the shared SPI flash pads: management flash controller
// and housekeeping pass-thru. Ownership changes only on transaction boundaries.
module spi_flash_share_arbiter #(
  parameter int CSB_GAP  = 4,
  parameter int HOLD_MAX = 65535,
  parameter int PT_PRIO  = 1
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       mgmt_req,
  output logic       mgmt_gnt,
  input  logic       mgmt_csb,
  input  logic       mgmt_sck,
  input  logic       mgmt_io0,
  output logic       mgmt_io1,
  input  logic       pt_req,
  output logic       pt_gnt,
  input  logic       pt_csb,
  input  logic       pt_sck,
  input  logic       pt_io0,
  output logic       pt_io1,
  output logic       flash_csb,
  output logic       flash_clk,
  output logic       flash_io0,
  output logic       flash_io0_oeb,
  input  logic       flash_io1,
  output logic [1:0] owner,
  output logic       timeout_err,
  output logic [1:0] dbg_state
);

  // Request/grant handshake: x_req is a level held by the master for as long as
  // it wants the bus; x_gnt is a registered level that rises one cycle after
  // x_req is sampled high in IDLE and falls on the edge after the master has
  // both dropped x_req and raised x_csb. Nothing ever revokes a grant early.

  localparam int HW = $clog2(HOLD_MAX + 1);
  localparam logic [HW-1:0] HOLD_LIM = HW'(HOLD_MAX);
  localparam logic [3:0]    GAP_LOAD = 4'(CSB_GAP - 1);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    OWN_MGMT = 2'd1,
    OWN_PT   = 2'd2,
    GAP      = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic [3:0]      gap_q, gap_d;
  logic [HW-1:0]   hold_q, hold_d;
  logic            timeout_q, timeout_d;
  logic            last_pt_q, last_pt_d;
  logic            tie_to_pt;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= IDLE;
      gap_q     <= '0;
      hold_q    <= '0;
      timeout_q <= 1'b0;
      last_pt_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      gap_q     <= gap_d;
      hold_q    <= hold_d;
      timeout_q <= timeout_d;
      last_pt_q <= last_pt_d;
    end
  end

  // On a tie, fixed priority favours pass-thru; otherwise serve whoever waited.
  assign tie_to_pt = (PT_PRIO != 0) || !last_pt_q;

  always_comb begin
    state_d   = state_q;
    gap_d     = gap_q;
    last_pt_d = last_pt_q;
    case (state_q)
      IDLE: begin
        if (pt_req && (!mgmt_req || tie_to_pt)) begin
          state_d   = OWN_PT;
          last_pt_d = 1'b1;
        end else if (mgmt_req) begin
          state_d   = OWN_MGMT;
          last_pt_d = 1'b0;
        end
      end
      OWN_MGMT: begin
        if (!mgmt_req && mgmt_csb) begin
          state_d = GAP;
          gap_d   = GAP_LOAD;
        end
      end
      OWN_PT: begin
        if (!pt_req && pt_csb) begin
          state_d = GAP;
          gap_d   = GAP_LOAD;
        end
      end
      GAP: begin
        if (gap_q == 4'd0) begin
          state_d = IDLE;
        end else begin
          gap_d = gap_q - 4'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Pads follow the owner combinationally; every other state parks them idle.
  always_comb begin
    flash_csb     = 1'b1;
    flash_clk     = 1'b0;
    flash_io0     = 1'b0;
    flash_io0_oeb = 1'b1;
    mgmt_io1      = 1'b0;
    pt_io1        = 1'b0;
    case (state_q)
      OWN_MGMT: begin
        flash_csb     = mgmt_csb;
        flash_clk     = mgmt_sck;
        flash_io0     = mgmt_io0;
        flash_io0_oeb = 1'b0;
        mgmt_io1      = flash_io1;
      end
      OWN_PT: begin
        flash_csb     = pt_csb;
        flash_clk     = pt_sck;
        flash_io0     = pt_io0;
        flash_io0_oeb = 1'b0;
        pt_io1        = flash_io1;
      end
      default: ;
    endcase
  end

  // Hold counter measures one continuous csb-low stretch of the current owner.
  always_comb begin
    hold_d    = '0;
    timeout_d = timeout_q;
    if ((state_q == OWN_MGMT || state_q == OWN_PT) && !flash_csb) begin
      hold_d = (hold_q == HOLD_LIM) ? hold_q : hold_q + HW'(1);
    end
    if (hold_d == HOLD_LIM) begin
      timeout_d = 1'b1;
    end
  end

  assign mgmt_gnt    = (state_q == OWN_MGMT);
  assign pt_gnt      = (state_q == OWN_PT);
  assign owner       = (state_q == OWN_MGMT) ? 2'd1 :
                       (state_q == OWN_PT)   ? 2'd2 : 2'd0;
  assign timeout_err = timeout_q;
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_spi_flash_share_arbiter.sv
// Bench for spi_flash_share_arbiter: two instances (fixed priority and round-robin)
// share one stimulus and are compared each cycle against a behavioural ownership model.
module tb_spi_flash_share_arbiter;

  localparam int CSB_GAP  = 4;
  localparam int HOLD_MAX = 100;

  logic clock = 1'b0;
  logic reset;
  logic mgmt_req, mgmt_csb, mgmt_sck, mgmt_io0;
  logic pt_req, pt_csb, pt_sck, pt_io0;
  logic flash_io1 = 1'b0;

  logic       a_mgmt_gnt, a_mgmt_io1, a_pt_gnt, a_pt_io1;
  logic       a_flash_csb, a_flash_clk, a_flash_io0, a_flash_io0_oeb, a_timeout_err;
  logic [1:0] a_owner, a_dbg_state;
  logic       b_mgmt_gnt, b_mgmt_io1, b_pt_gnt, b_pt_io1;
  logic       b_flash_csb, b_flash_clk, b_flash_io0, b_flash_io0_oeb, b_timeout_err;
  logic [1:0] b_owner, b_dbg_state;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clock = ~clock;

  spi_flash_share_arbiter #(.CSB_GAP(CSB_GAP), .HOLD_MAX(HOLD_MAX), .PT_PRIO(1)) dut_a (
    .clock(clock), .reset(reset),
    .mgmt_req(mgmt_req), .mgmt_gnt(a_mgmt_gnt), .mgmt_csb(mgmt_csb), .mgmt_sck(mgmt_sck),
    .mgmt_io0(mgmt_io0), .mgmt_io1(a_mgmt_io1),
    .pt_req(pt_req), .pt_gnt(a_pt_gnt), .pt_csb(pt_csb), .pt_sck(pt_sck),
    .pt_io0(pt_io0), .pt_io1(a_pt_io1),
    .flash_csb(a_flash_csb), .flash_clk(a_flash_clk), .flash_io0(a_flash_io0),
    .flash_io0_oeb(a_flash_io0_oeb), .flash_io1(flash_io1),
    .owner(a_owner), .timeout_err(a_timeout_err), .dbg_state(a_dbg_state)
  );

  spi_flash_share_arbiter #(.CSB_GAP(CSB_GAP), .HOLD_MAX(HOLD_MAX), .PT_PRIO(0)) dut_b (
    .clock(clock), .reset(reset),
    .mgmt_req(mgmt_req), .mgmt_gnt(b_mgmt_gnt), .mgmt_csb(mgmt_csb), .mgmt_sck(mgmt_sck),
    .mgmt_io0(mgmt_io0), .mgmt_io1(b_mgmt_io1),
    .pt_req(pt_req), .pt_gnt(b_pt_gnt), .pt_csb(pt_csb), .pt_sck(pt_sck),
    .pt_io0(pt_io0), .pt_io1(b_pt_io1),
    .flash_csb(b_flash_csb), .flash_clk(b_flash_clk), .flash_io0(b_flash_io0),
    .flash_io0_oeb(b_flash_io0_oeb), .flash_io1(flash_io1),
    .owner(b_owner), .timeout_err(b_timeout_err), .dbg_state(b_dbg_state)
  );

  // ---------------- SPI flash model (mode 0, READ 0x03) on instance a pads
  logic [7:0]  mem [0:255];
  logic [31:0] f_shift = '0;
  int          f_bits  = 0;

  always @(posedge a_flash_clk or posedge a_flash_csb) begin
    if (a_flash_csb) begin
      f_bits = 0;
    end else begin
      if (f_bits < 32) f_shift = {f_shift[30:0], a_flash_io0};
      f_bits++;
    end
  end

  always @(negedge a_flash_clk) begin
    if (!a_flash_csb && f_bits >= 32 && f_shift[31:24] == 8'h03) begin
      automatic int k = f_bits - 32;
      automatic logic [7:0] adr = f_shift[7:0] + 8'(k / 8);
      automatic logic [7:0] byt = mem[adr];
      flash_io1 = byt[7 - (k % 8)];
    end
  end

  // ---------------- reference model: who owns the bus, how long the gap lasts
  int m_own  [2];   // 0 none, 1 mgmt, 2 pass-thru
  int m_gap  [2];   // pad-idle cycles still to serve before a new grant
  int m_hold [2];   // consecutive csb-low cycles of the current owner
  bit m_tout [2];
  bit m_lastpt[2];
  int m_prio [2] = '{1, 0};

  function automatic logic own_csb(input int o);
    return (o == 1) ? mgmt_csb : (o == 2) ? pt_csb : 1'b1;
  endfunction

  task automatic model_update();
    for (int i = 0; i < 2; i++) begin
      if (reset) begin
        m_own[i] = 0; m_gap[i] = 0; m_hold[i] = 0; m_tout[i] = 0; m_lastpt[i] = 0;
      end else begin
        automatic logic c = own_csb(m_own[i]);
        if (m_own[i] != 0 && !c) m_hold[i] = (m_hold[i] < HOLD_MAX) ? m_hold[i] + 1 : m_hold[i];
        else m_hold[i] = 0;
        if (m_hold[i] == HOLD_MAX) m_tout[i] = 1;
        if (m_own[i] != 0) begin
          automatic logic r = (m_own[i] == 1) ? mgmt_req : pt_req;
          if (!r && c) begin
            m_own[i] = 0;
            m_gap[i] = CSB_GAP;
          end
        end else if (m_gap[i] > 0) begin
          m_gap[i]--;
        end else if (mgmt_req || pt_req) begin
          if (mgmt_req && pt_req) m_own[i] = (m_prio[i] != 0) ? 2 : (m_lastpt[i] ? 1 : 2);
          else m_own[i] = pt_req ? 2 : 1;
          m_lastpt[i] = (m_own[i] == 2);
        end
      end
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_inst(input int i, input string p,
                            input logic mg, input logic pg, input logic [1:0] ow,
                            input logic csb, input logic clk, input logic io0, input logic oeb,
                            input logic mio1, input logic pio1, input logic tout);
    automatic int o = m_own[i];
    chk({p, "mgmt_gnt"}, 32'(mg), 32'(o == 1));
    chk({p, "pt_gnt"},   32'(pg), 32'(o == 2));
    chk({p, "owner"},    32'(ow), 32'(o));
    chk({p, "flash_csb"}, 32'(csb), 32'(own_csb(o)));
    chk({p, "flash_clk"}, 32'(clk), 32'((o == 1) ? mgmt_sck : (o == 2) ? pt_sck : 1'b0));
    chk({p, "flash_io0"}, 32'(io0), 32'((o == 1) ? mgmt_io0 : (o == 2) ? pt_io0 : 1'b0));
    chk({p, "flash_oeb"}, 32'(oeb), 32'(o == 0));
    chk({p, "mgmt_io1"}, 32'(mio1), 32'((o == 1) ? flash_io1 : 1'b0));
    chk({p, "pt_io1"},   32'(pio1), 32'((o == 2) ? flash_io1 : 1'b0));
    chk({p, "timeout"},  32'(tout), 32'(m_tout[i]));
  endtask

  // One clock: model and DUT advance on the same edge, outputs compared at negedge.
  task automatic tick();
    @(posedge clock);
    model_update();
    @(negedge clock);
    check_inst(0, "a.", a_mgmt_gnt, a_pt_gnt, a_owner, a_flash_csb, a_flash_clk, a_flash_io0,
               a_flash_io0_oeb, a_mgmt_io1, a_pt_io1, a_timeout_err);
    check_inst(1, "b.", b_mgmt_gnt, b_pt_gnt, b_owner, b_flash_csb, b_flash_clk, b_flash_io0,
               b_flash_io0_oeb, b_mgmt_io1, b_pt_io1, b_timeout_err);
  endtask

  task automatic set_pins(input int who, input logic csb, input logic sck, input logic io0);
    if (who == 0) begin mgmt_csb = csb; mgmt_sck = sck; mgmt_io0 = io0; end
    else          begin pt_csb = csb;   pt_sck = sck;   pt_io0 = io0;   end
  endtask

  // READ 0x03 of one byte at addr, sampling MISO on each rising SCK.
  task automatic read_byte(input int who, input logic [23:0] addr, output logic [7:0] d);
    automatic logic [31:0] cmd = {8'h03, addr};
    d = '0;
    for (int i = 0; i < 40; i++) begin
      set_pins(who, 1'b0, 1'b0, (i < 32) ? cmd[31 - i] : 1'b0);
      tick();
      if (i >= 32) d = {d[6:0], (who == 0) ? a_mgmt_io1 : a_pt_io1};
      set_pins(who, 1'b0, 1'b1, (i < 32) ? cmd[31 - i] : 1'b0);
      tick();
    end
    set_pins(who, 1'b1, 1'b0, 1'b0);
    tick();
  endtask

  initial begin
    automatic logic [7:0] boot [5] = '{8'h6f, 8'h00, 8'h00, 8'h0b, 8'h93};
    automatic int rr_exp [4] = '{1, 2, 1, 2};
    automatic logic [7:0] d;
    automatic int n;

    for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
    for (int i = 0; i < 5; i++) mem[i] = boot[i];

    reset = 1'b1;
    mgmt_req = 1'b0; pt_req = 1'b0;
    set_pins(0, 1'b1, 1'b0, 1'b0);
    set_pins(1, 1'b1, 1'b0, 1'b0);
    repeat (3) tick();
    chk("rst.owner", 32'(a_owner), 0);
    chk("rst.flash_csb", 32'(a_flash_csb), 1);
    chk("rst.flash_oeb", 32'(a_flash_io0_oeb), 1);
    chk("rst.flash_clk", 32'(a_flash_clk), 0);
    chk("rst.timeout", 32'(a_timeout_err), 0);
    reset = 1'b0;
    tick();

    // mgmt boot reads, csb toggling between bytes
    mgmt_req = 1'b1;
    tick();
    chk("t1.mgmt_gnt", 32'(a_mgmt_gnt), 1);
    chk("t1.owner", 32'(a_owner), 1);
    for (int i = 0; i < 5; i++) begin
      read_byte(0, 24'(i), d);
      chk("t1.boot_byte", 32'(d), 32'(boot[i]));
    end

    // pass-thru waits out an active mgmt transaction, then the gap
    mgmt_csb = 1'b0;
    pt_req = 1'b1;
    repeat (10) begin
      tick();
      chk("t2.pt_gnt_blocked", 32'(a_pt_gnt), 0);
    end
    mgmt_req = 1'b0;
    mgmt_csb = 1'b1;
    tick();
    n = 0;
    while (!a_pt_gnt && n < 20) begin
      chk("t2.gap_csb", 32'(a_flash_csb), 1);
      tick();
      n++;
    end
    chk("t2.gap_len", 32'(n), 32'(CSB_GAP + 1));
    chk("t2.pt_gnt", 32'(a_pt_gnt), 1);
    read_byte(1, 24'h000000, d);
    chk("t2.pt_read", 32'(d), 32'h6f);
    pt_req = 1'b0;
    repeat (8) tick();

    // simultaneous requests
    for (int r = 0; r < 4; r++) begin
      mgmt_req = 1'b1; pt_req = 1'b1;
      tick();
      chk("t3.prio_owner", 32'(a_owner), 2);
      chk("t3.rr_owner", 32'(b_owner), 32'(rr_exp[r]));
      mgmt_req = 1'b0; pt_req = 1'b0;
      repeat (8) tick();
    end

    // owner drops req mid-transaction; non-owner wiggles its pins
    pt_req = 1'b1;
    tick();
    pt_csb = 1'b0;
    tick();
    pt_req = 1'b0;
    for (int i = 0; i < 20; i++) begin
      pt_sck = 1'($urandom); pt_io0 = 1'($urandom);
      mgmt_csb = 1'($urandom); mgmt_sck = 1'($urandom);
      tick();
      chk("t4.pt_gnt_held", 32'(a_pt_gnt), 1);
      chk("t4.flash_csb", 32'(a_flash_csb), 0);
    end
    set_pins(0, 1'b1, 1'b0, 1'b0);
    set_pins(1, 1'b1, 1'b0, 1'b0);
    tick();
    chk("t4.released", 32'(a_owner), 0);
    repeat (8) tick();

    // hold timeout
    mgmt_req = 1'b1;
    tick();
    mgmt_csb = 1'b0;
    for (int k = 1; k <= 150; k++) begin
      tick();
      if (k == HOLD_MAX - 1) chk("t5.timeout_early", 32'(a_timeout_err), 0);
      if (k == HOLD_MAX) chk("t5.timeout_set", 32'(a_timeout_err), 1);
    end
    chk("t5.owner_kept", 32'(a_owner), 1);
    mgmt_req = 1'b0;
    mgmt_csb = 1'b1;
    repeat (8) tick();
    chk("t5.timeout_sticky", 32'(a_timeout_err), 1);
    chk("t5.timeout_sticky_b", 32'(b_timeout_err), 1);

    // reset during a pass-thru transaction
    pt_req = 1'b1;
    tick();
    pt_csb = 1'b0;
    repeat (5) tick();
    chk("t6.pre_csb", 32'(a_flash_csb), 0);
    reset = 1'b1;
    tick();
    chk("t6.flash_csb", 32'(a_flash_csb), 1);
    chk("t6.flash_oeb", 32'(a_flash_io0_oeb), 1);
    chk("t6.pt_gnt", 32'(a_pt_gnt), 0);
    chk("t6.owner", 32'(a_owner), 0);
    chk("t6.timeout", 32'(a_timeout_err), 0);
    reset = 1'b0;
    pt_req = 1'b0;
    pt_csb = 1'b1;
    tick();

    // random traffic
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 15) == 0) mgmt_req = ~mgmt_req;
      if ($urandom_range(0, 15) == 0) pt_req = ~pt_req;
      if ($urandom_range(0, 3) == 0) mgmt_csb = ~mgmt_csb;
      if ($urandom_range(0, 3) == 0) pt_csb = ~pt_csb;
      mgmt_sck = 1'($urandom); mgmt_io0 = 1'($urandom);
      pt_sck = 1'($urandom);   pt_io0 = 1'($urandom);
      reset = ($urandom_range(0, 499) == 0);
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
